// File: rtl/fft_pkg.sv
// Shared constants for the FFT output path: sample width, lane count, lane packing.
package fft_pkg;

  localparam int FFT_DW     = 64;
  localparam int LANES      = 4;
  localparam int LANE_IDX_W = 2;

  // Packed-word slot per lane (2 bits each, lane 0 in the LSBs): word = {D3,D2,D1,D0}.
  localparam logic [2*LANES-1:0] LANE_SLOT = 8'b11_10_01_00;

  function automatic int cnt_width(input int n_points);
    return (n_points > 1) ? $clog2(n_points) : 1;
  endfunction

endpackage

// File: rtl/fft_word_fifo.sv
// Generic DEPTH x W synchronous FIFO with first-word-fall-through head output.
module fft_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 256,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head is read asynchronously so a freshly written word is visible the next cycle.
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fft_out_serializer.sv
// Buffers 4-lane FFT result words and emits them one sample per cycle in lane order,
// with frame-boundary marking and a sticky input-overrun flag.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int N_POINTS = 4096,
  parameter int DW       = FFT_DW
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [DW-1:0] D0,
  input  logic [DW-1:0] D1,
  input  logic [DW-1:0] D2,
  input  logic [DW-1:0] D3,
  input  logic          IN_VALID,
  output logic          IN_READY,
  output logic [DW-1:0] Q,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          OUT_LAST,
  output logic          FRAME_DONE,
  output logic          OVF,
  input  logic          CLR_OVF
);

  localparam int CW = cnt_width(N_POINTS);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = LANES * DW;

  logic [DW-1:0]         d_lane    [LANES];
  logic [DW-1:0]         head_lane [LANES];
  logic [WW-1:0]         in_word;
  logic [WW-1:0]         head_word;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [AW:0]           fifo_count;
  logic [LANE_IDX_W-1:0] lane_idx;
  logic [CW-1:0]         sample_cnt;
  logic                  push;
  logic                  pop;
  logic                  xfer;

  assign d_lane[0] = D0;
  assign d_lane[1] = D1;
  assign d_lane[2] = D2;
  assign d_lane[3] = D3;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int SLOT = int'(LANE_SLOT[2*gi +: 2]);
    assign in_word[SLOT*DW +: DW] = d_lane[gi];
    assign head_lane[gi]          = head_word[SLOT*DW +: DW];
  end

  fft_word_fifo #(
    .DEPTH (DEPTH),
    .W     (WW)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RSTn),
    .push  (push),
    .pop   (pop),
    .wdata (in_word),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Readiness depends only on stored occupancy, never on OUT_READY.
  assign IN_READY  = (fifo_count != (AW+1)'(DEPTH));
  assign OUT_VALID = ~fifo_empty;
  assign push      = IN_VALID & ~fifo_full;
  assign xfer      = OUT_VALID & OUT_READY;
  assign pop       = xfer & (lane_idx == LANE_IDX_W'(LANES - 1));
  assign Q         = OUT_VALID ? head_lane[lane_idx] : '0;
  assign OUT_LAST  = OUT_VALID & (sample_cnt == CW'(N_POINTS - 1));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      lane_idx   <= '0;
      sample_cnt <= '0;
      FRAME_DONE <= 1'b0;
      OVF        <= 1'b0;
    end else begin
      if (xfer) begin
        lane_idx   <= lane_idx + LANE_IDX_W'(1);
        sample_cnt <= sample_cnt + CW'(1);
      end
      FRAME_DONE <= xfer & OUT_LAST;
      if (IN_VALID & ~IN_READY) OVF <= 1'b1;
      else if (CLR_OVF)         OVF <= 1'b0;
    end
  end

endmodule

// File: doc/fft_out_serializer.md
Name: fft_out_serializer

Overview:
Downstream stage of the 4-lane FFT core. It captures 4-lane result words (four 64-bit complex samples per word) and buffers them in a small FIFO. It serializes them into a one-sample-per-cycle valid/ready stream in lane order 0,1,2,3. It also marks frame boundaries (N_POINTS samples) and flags input overrun.

Parameters:
DEPTH, 4, FIFO depth in 4-lane words; power of 2, at least 2
N_POINTS, 4096, samples per FFT frame; power of 2, multiple of 4
DW, 64, sample width (upper DW/2 = real, lower DW/2 = imag; passed through untouched)

Ports:
CLK  input  1  clock, all logic on rising edge
RSTn  input  1  reset, asynchronous, active-low
D0  input  DW  lane 0 sample (emitted first)
D1  input  DW  lane 1 sample
D2  input  DW  lane 2 sample
D3  input  DW  lane 3 sample (emitted last)
IN_VALID  input  1  D0..D3 hold a valid word this cycle
IN_READY  output  1  FIFO can accept a word
Q  output  DW  serialized sample
OUT_VALID  output  1  Q valid
OUT_READY  input  1  sink accepts Q
OUT_LAST  output  1  Q is the final sample of a frame
FRAME_DONE  output  1  one-cycle pulse after the last sample of a frame transfers
OVF  output  1  sticky: a word was offered while IN_READY=0
CLR_OVF  input  1  clears OVF

Behaviour:
- Reset (RSTn=0, async): rd/wr pointers, count, lane index, sample counter, FRAME_DONE and OVF all go to 0. IN_READY=1, OUT_VALID=0, OUT_LAST=0, Q=0. FIFO storage is not reset; its contents are discarded. Reset mid-frame drops all buffered data and the partial frame.
- Push: IN_VALID & IN_READY at an edge writes {D3,D2,D1,D0} at wr_ptr; wr_ptr advances modulo DEPTH.
- IN_READY = (count != DEPTH). This is registered state only; there is no combinational path from OUT_READY.
- OUT_VALID = (count != 0).
- Q = head word lane[lane_idx] when OUT_VALID, else 0.
- Latency: a word pushed at edge k gives OUT_VALID=1 with lane 0 on Q during cycle k+1 (FIFO previously empty).
- Transfer = OUT_VALID & OUT_READY. On a transfer, lane_idx increments (2-bit, wraps 3->0). When lane_idx==3 the head word pops and rd_ptr advances modulo DEPTH.
- Q, OUT_VALID and OUT_LAST stay stable while OUT_VALID=1 and OUT_READY=0.
- Simultaneous push and pop in one cycle: count is unchanged. A push while full is impossible because IN_READY=0.
- Sample counter, log2(N_POINTS) bits: increments on each transfer and wraps N_POINTS-1 -> 0.
- OUT_LAST = OUT_VALID & (sample_cnt == N_POINTS-1).
- FRAME_DONE: registered, high for exactly one cycle after the edge at which the OUT_LAST transfer occurs.
- OVF: set at an edge where IN_VALID=1 & IN_READY=0. Cleared when CLR_OVF=1. If set and clear occur in the same cycle, set wins. A rejected word is dropped and the FIFO is unaffected.
- Throughput: 1 sample/cycle sustained. The upstream may push at most 1 word per 4 cycles without backpressure.

Decomposition:
- Shared package fft_pkg: DW, lane count (4), and the lane-packing order constant. Also a function giving the sample-counter width from N_POINTS.
- One sub-module, fft_word_fifo: a generic DEPTH x 4*DW synchronous FIFO with push/pop, full/empty and count. The serializer logic (lane index, frame counter, OVF) stays in fft_out_serializer.

Test Plan:
- Reset, then one word D0..D3 = 0xA0, 0xA1, 0xA2, 0xA3 with OUT_READY=1 -> OUT_VALID rises the next cycle; Q = A0, A1, A2, A3 on 4 consecutive cycles; then OUT_VALID=0.
- Push DEPTH+1 words back-to-back with OUT_READY=0 -> IN_READY=0 after DEPTH pushes; the extra word sets OVF=1; releasing OUT_READY yields exactly 4*DEPTH samples in order. CLR_OVF -> OVF=0. CLR_OVF with a simultaneous overrun -> OVF stays 1.
- Random OUT_READY toggling (50%) over 8 words -> Q is stable whenever stalled; the output sequence equals the input samples in lane order with no loss or duplication.
- Full frame with N_POINTS=16: 4 words, OUT_READY=1 -> OUT_LAST high only on the 16th sample; FRAME_DONE pulses one cycle later; a second frame's OUT_LAST falls again on sample 32.
- Assert RSTn=0 mid-word (lane_idx=2, 2 words buffered) -> outputs return to their reset values immediately. After release, a new word starts at lane 0 and the sample counter restarts at 0.
- Push and pop in the same cycle at count=DEPTH-1 -> count is unchanged and IN_READY stays 1.
